paddle_input_controller: RTL and testbench

//  Converts raw, bouncy board buttons (btnU/btnD) into a clamped paddle position for the pong game.

---
 rtl/paddle_input_controller_pkg.sv | 49 ++++
 rtl/paddle_input_controller_debouncer.sv | 35 +++
 rtl/paddle_input_controller.sv | 139 +++++++++++++
 tb/tb_paddle_input_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_input_controller_pkg.sv
// Shared constants, FSM/direction encodings and the clamped step helper
// for the paddle input path.
package paddle_input_controller_pkg;

  localparam int SCREEN_HEIGHT  = 480;
  localparam int PADDLE_LENGTH  = 80;
  localparam int DEF_PADDLE_MIN = 0;
  localparam int DEF_PADDLE_MAX = SCREEN_HEIGHT - PADDLE_LENGTH;
  localparam int DEF_RESET_LOC  = DEF_PADDLE_MAX / 2;
  localparam int DEF_STEP       = 8;
  localparam int LOC_W          = 10;

  typedef logic [LOC_W-1:0] loc_t;
  typedef logic [LOC_W:0]   wide_loc_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_REPEAT = 2'd2
  } paddle_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } paddle_dir_e;

  // One extra bit of headroom, so the sum and difference can never wrap
  // before they are clamped into [lo, hi].
  function automatic loc_t step_loc(input loc_t loc, input paddle_dir_e dir,
                                    input int step, input int lo, input int hi);
    wide_loc_t wide;
    wide_loc_t s;
    wide_loc_t lo_w;
    wide_loc_t hi_w;
    wide_loc_t res;
    wide = {1'b0, loc};
    s    = wide_loc_t'(step);
    lo_w = wide_loc_t'(lo);
    hi_w = wide_loc_t'(hi);
    case (dir)
      DIR_UP:   res = (wide >= lo_w + s) ? wide - s : lo_w;
      DIR_DOWN: res = (wide + s > hi_w) ? hi_w : wide + s;
      default:  res = wide;
    endcase
    return res[LOC_W-1:0];
  endfunction

endpackage

// File: rtl/paddle_input_controller_debouncer.sv
// Two-flop synchroniser followed by a stability counter: the debounced
// level only follows the synced input after DEBOUNCE_CYCLES consecutive differing samples.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_input_controller.sv
// Debounced up/down buttons drive a clamped paddle position: one step on
// press, then auto-repeat after a delay while the same direction is held.
module paddle_input_controller
  import paddle_input_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 2,
  parameter int STEP            = DEF_STEP,
  parameter int PADDLE_MIN      = DEF_PADDLE_MIN,
  parameter int PADDLE_MAX      = DEF_PADDLE_MAX,
  parameter int RESET_LOC       = DEF_RESET_LOC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             enable,
  input  logic             recentre,
  output logic [LOC_W-1:0] paddle_loc,
  output logic             step_pulse,
  output logic             at_limit
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
  localparam loc_t RESET_VAL = LOC_W'(RESET_LOC);

  logic          up_level;
  logic          down_level;
  paddle_dir_e   dir;
  paddle_state_e state, state_next;
  paddle_dir_e   cur_dir, dir_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  loc_t          loc_next;
  logic          pulse_next;
  logic          do_step;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_up),
    .level   (up_level)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_down),
    .level   (down_level)
  );

  always_comb begin
    dir = DIR_NONE;
    if (up_level && !down_level) dir = DIR_UP;
    else if (down_level && !up_level) dir = DIR_DOWN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cur_dir    <= DIR_NONE;
      cnt        <= '0;
      paddle_loc <= RESET_VAL;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      cur_dir    <= dir_next;
      cnt        <= cnt_next;
      paddle_loc <= loc_next;
      step_pulse <= pulse_next;
    end
  end

  // Recentre outranks everything, then enable; a reversal in FIRST/REPEAT
  // restarts the press sequence in the new direction.
  always_comb begin
    state_next = state;
    dir_next   = cur_dir;
    cnt_next   = cnt;
    do_step    = 1'b0;
    loc_next   = paddle_loc;
    pulse_next = 1'b0;
    if (recentre) begin
      state_next = ST_IDLE;
      dir_next   = DIR_NONE;
      cnt_next   = '0;
      loc_next   = RESET_VAL;
      pulse_next = (paddle_loc != RESET_VAL);
    end else if (!enable) begin
      state_next = ST_IDLE;
      dir_next   = DIR_NONE;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dir != DIR_NONE) begin
            state_next = ST_FIRST;
            dir_next   = dir;
            cnt_next   = DELAY_LOAD;
            do_step    = 1'b1;
          end
        end
        ST_FIRST, ST_REPEAT: begin
          if (dir == DIR_NONE) begin
            state_next = ST_IDLE;
            dir_next   = DIR_NONE;
            cnt_next   = '0;
          end else if (dir != cur_dir) begin
            state_next = ST_FIRST;
            dir_next   = dir;
            cnt_next   = DELAY_LOAD;
            do_step    = 1'b1;
          end else if (cnt == '0) begin
            state_next = ST_REPEAT;
            cnt_next   = PERIOD_LOAD;
            do_step    = 1'b1;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          dir_next   = DIR_NONE;
          cnt_next   = '0;
        end
      endcase
      if (do_step) begin
        loc_next   = step_loc(paddle_loc, dir_next, STEP, PADDLE_MIN, PADDLE_MAX);
        pulse_next = (loc_next != paddle_loc);
      end
    end
  end

  assign at_limit = (paddle_loc == LOC_W'(PADDLE_MIN)) || (paddle_loc == LOC_W'(PADDLE_MAX));

endmodule

// File: tb/tb_paddle_input_controller.sv
// Directed bench for paddle_input_controller: tap, bounce, hold/saturate,
// reset mid-move, conflict/reversal, enable freeze and recentre.
module tb_paddle_input_controller;
  import paddle_input_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_up;
  logic       btn_down;
  logic       enable;
  logic       recentre;
  logic [9:0] paddle_loc;
  logic       step_pulse;
  logic       at_limit;

  int checks = 0;
  int errors = 0;

  paddle_input_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .enable     (enable),
    .recentre   (recentre),
    .paddle_loc (paddle_loc),
    .step_pulse (step_pulse),
    .at_limit   (at_limit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_count(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (step_pulse === 1'b1) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int exp_loc;
    int nxt;
    logic exp_pulse;
    logic done;

    reset_n  = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    enable   = 1'b1;
    recentre = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    check("reset_loc", 32'(paddle_loc), 32'd200);
    check("reset_pulse", 32'(step_pulse), 32'd0);
    check("reset_at_limit", 32'(at_limit), 32'd0);
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));

    // Tap: one step at the 7th edge, nothing more within 10 cycles
    btn_up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("tap_loc", 32'(paddle_loc), (i >= 7) ? 32'd192 : 32'd200);
      check("tap_pulse", 32'(step_pulse), (i == 7) ? 32'd1 : 32'd0);
    end
    btn_up = 1'b0;
    run_count(15, pulses);
    check("tap_release_pulses", 32'(pulses), 32'd0);
    check("tap_release_loc", 32'(paddle_loc), 32'd192);

    // Bounce: single-cycle glitches never get through the debouncer
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      btn_down = i[0];
      tick();
      if (step_pulse === 1'b1) pulses++;
    end
    btn_down = 1'b0;
    run_count(10, nxt);
    check("bounce_pulses", 32'(pulses + nxt), 32'd0);
    check("bounce_loc", 32'(paddle_loc), 32'd192);
    check("bounce_state", 32'(dut.state), 32'(ST_IDLE));

    // Hold up down to 136, then drop reset mid-move
    btn_up = 1'b1;
    exp_loc = 192;
    for (int i = 1; i <= 37; i++) begin
      tick();
      if (i == 7 || (i >= 27 && i[0])) exp_loc = exp_loc - 8;
      check("hold_up_loc", 32'(paddle_loc), 32'(exp_loc));
    end
    check("pre_reset_loc", 32'(paddle_loc), 32'd136);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_loc", 32'(paddle_loc), 32'd200);
    check("async_reset_pulse", 32'(step_pulse), 32'd0);
    check("async_reset_state", 32'(dut.state), 32'(ST_IDLE));
    tick();
    reset_n = 1'b1;
    run_count(6, pulses);
    check("post_reset_quiet", 32'(pulses), 32'd0);
    check("post_reset_loc", 32'(paddle_loc), 32'd200);
    tick();
    check("post_reset_step_loc", 32'(paddle_loc), 32'd192);
    check("post_reset_step_pulse", 32'(step_pulse), 32'd1);
    btn_up = 1'b0;
    run_count(10, pulses);
    check("post_reset_release", 32'(pulses), 32'd0);

    // Hold down: steps at 7, 27, 29, ... saturating at 400
    btn_down = 1'b1;
    exp_loc = 192;
    for (int i = 1; i <= 80; i++) begin
      tick();
      exp_pulse = 1'b0;
      if (i == 7 || (i >= 27 && i[0])) begin
        nxt = (exp_loc + 8 > 400) ? 400 : exp_loc + 8;
        exp_pulse = (nxt != exp_loc);
        exp_loc = nxt;
      end
      check("hold_down_loc", 32'(paddle_loc), 32'(exp_loc));
      check("hold_down_pulse", 32'(step_pulse), 32'(exp_pulse));
    end
    check("max_loc", 32'(paddle_loc), 32'd400);
    check("max_at_limit", 32'(at_limit), 32'd1);

    // Recentre while held, then held button re-triggers FIRST
    recentre = 1'b1;
    tick();
    recentre = 1'b0;
    check("recentre_loc", 32'(paddle_loc), 32'd200);
    check("recentre_pulse", 32'(step_pulse), 32'd1);
    check("recentre_state", 32'(dut.state), 32'(ST_IDLE));
    tick();
    check("retrigger_loc", 32'(paddle_loc), 32'd208);
    check("retrigger_pulse", 32'(step_pulse), 32'd1);

    // Conflict: both held gives no motion
    btn_up = 1'b1;
    run_count(20, pulses);
    check("conflict_pulses", 32'(pulses), 32'd0);
    check("conflict_loc", 32'(paddle_loc), 32'd208);
    check("conflict_state", 32'(dut.state), 32'(ST_IDLE));

    // Release up: FIRST step, repeat after 20; reverse at edge 27
    btn_up = 1'b0;
    exp_loc = 208;
    for (int i = 1; i <= 40; i++) begin
      tick();
      exp_pulse = 1'b0;
      if (i == 34) begin
        exp_loc = exp_loc - 8;
        exp_pulse = 1'b1;
      end else if (i == 7 || (i >= 27 && i <= 33 && i[0])) begin
        exp_loc = exp_loc + 8;
        exp_pulse = 1'b1;
      end
      check("resolve_loc", 32'(paddle_loc), 32'(exp_loc));
      check("resolve_pulse", 32'(step_pulse), 32'(exp_pulse));
      if (i == 27) begin
        btn_up   = 1'b1;
        btn_down = 1'b0;
      end
    end
    check("reverse_loc", 32'(paddle_loc), 32'd240);
    check("reverse_state", 32'(dut.state), 32'(ST_FIRST));

    // Enable low freezes and idles; re-enable steps at once
    enable = 1'b0;
    tick();
    check("disable_state", 32'(dut.state), 32'(ST_IDLE));
    check("disable_pulse", 32'(step_pulse), 32'd0);
    run_count(20, pulses);
    check("disable_pulses", 32'(pulses), 32'd0);
    check("disable_loc", 32'(paddle_loc), 32'd240);
    enable = 1'b1;
    tick();
    check("enable_loc", 32'(paddle_loc), 32'd232);
    check("enable_pulse", 32'(step_pulse), 32'd1);
    check("enable_state", 32'(dut.state), 32'(ST_FIRST));

    // Drive up to the top limit (bounded wait)
    done = 1'b0;
    for (int i = 0; i < 120 && !done; i++) begin
      tick();
      if (paddle_loc == 10'd0) done = 1'b1;
    end
    check("min_reached", 32'(done), 32'd1);
    check("min_at_limit", 32'(at_limit), 32'd1);
    run_count(6, pulses);
    check("min_no_pulse", 32'(pulses), 32'd0);
    check("min_hold_loc", 32'(paddle_loc), 32'd0);
    btn_up = 1'b0;
    run_count(10, pulses);

    // Recentre from 0, then again when already centred
    recentre = 1'b1;
    tick();
    recentre = 1'b0;
    check("recentre0_loc", 32'(paddle_loc), 32'd200);
    check("recentre0_pulse", 32'(step_pulse), 32'd1);
    tick();
    check("recentre0_after_pulse", 32'(step_pulse), 32'd0);
    recentre = 1'b1;
    tick();
    recentre = 1'b0;
    check("recentre_same_loc", 32'(paddle_loc), 32'd200);
    check("recentre_same_pulse", 32'(step_pulse), 32'd0);
    check("centre_at_limit", 32'(at_limit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
